// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS-I integer subset core with separate instruction and data ports.
// Optional MULT/MULTU/MFHI/MFLO/MTHI/MTLO support is built when MIPS_MULDIV_EN is defined.
module mips_harvard_cpu #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   input  logic        clk_enable,
   output logic [31:0] instr_address,
   input  logic [31:0] instr_readdata,
   output logic [31:0] data_address,
   output logic        data_write,
   output logic        data_read,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;
`ifdef MIPS_MULDIV_EN
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
`endif

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] npc;
   logic [XLEN-1:0] gpr [NREGS];

   logic [5:0]      op;
   logic [5:0]      funct;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [4:0]      shamt;
   logic [15:0]     imm;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic [XLEN-1:0] simm;
   logic [XLEN-1:0] zimm;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;
   logic [XLEN-1:0] link_addr;

   logic            advance;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] npc_next;
   logic            is_load;
   logic            is_store;

`ifdef MIPS_MULDIV_EN
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] hi_next;
   logic [XLEN-1:0] lo_next;
   logic            hilo_we;
   logic [63:0]     smul;
   logic [63:0]     umul;

   assign smul = 64'($signed(rs_val)) * 64'($signed(rt_val));
   assign umul = 64'(rs_val) * 64'(rt_val);
`endif

   // Instruction field extraction and operand fetch ($0 always reads zero).
   assign op        = instr_readdata[31:26];
   assign rs        = instr_readdata[25:21];
   assign rt        = instr_readdata[20:16];
   assign rd        = instr_readdata[15:11];
   assign shamt     = instr_readdata[10:6];
   assign funct     = instr_readdata[5:0];
   assign imm       = instr_readdata[15:0];
   assign rs_val    = (rs == 5'd0) ? '0 : gpr[rs];
   assign rt_val    = (rt == 5'd0) ? '0 : gpr[rt];
   assign simm      = {{16{imm[15]}}, imm};
   assign zimm      = {16'd0, imm};
   assign br_target = npc + {simm[29:0], 2'b00};
   assign j_target  = {npc[31:28], instr_readdata[25:0], 2'b00};
   assign link_addr = npc + 32'd4;

   assign advance        = clk_enable & active;
   assign instr_address  = pc;
   assign register_v0    = gpr[2];
   assign data_address   = rs_val + simm;
   assign data_writedata = rt_val;
   assign data_read      = active & is_load;
   // Gated by clk_enable so a stalled store is not repeated into memory.
   assign data_write     = advance & is_store;

   // Decode and execute: register writeback, next-PC selection, memory strobes.
   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = rd;
      wr_data  = '0;
      npc_next = npc + 32'd4;
      is_load  = 1'b0;
      is_store = 1'b0;
`ifdef MIPS_MULDIV_EN
      hilo_we  = 1'b0;
      hi_next  = hi;
      lo_next  = lo;
`endif
      case (op)
         OP_SPECIAL: begin
            case (funct)
               FN_SLL:  begin wr_en = 1'b1; wr_data = rt_val << shamt; end
               FN_SRL:  begin wr_en = 1'b1; wr_data = rt_val >> shamt; end
               FN_SRA:  begin wr_en = 1'b1; wr_data = XLEN'($signed(rt_val) >>> shamt); end
               FN_SLLV: begin wr_en = 1'b1; wr_data = rt_val << rs_val[4:0]; end
               FN_SRLV: begin wr_en = 1'b1; wr_data = rt_val >> rs_val[4:0]; end
               FN_SRAV: begin wr_en = 1'b1; wr_data = XLEN'($signed(rt_val) >>> rs_val[4:0]); end
               FN_JR:   npc_next = rs_val;
               FN_JALR: begin npc_next = rs_val; wr_en = 1'b1; wr_data = link_addr; end
               FN_ADDU: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
               FN_SUBU: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
               FN_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
               FN_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
               FN_XOR:  begin wr_en = 1'b1; wr_data = rs_val ^ rt_val; end
               FN_NOR:  begin wr_en = 1'b1; wr_data = ~(rs_val | rt_val); end
               FN_SLT:  begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
               FN_SLTU: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < rt_val}; end
`ifdef MIPS_MULDIV_EN
               FN_MFHI:  begin wr_en = 1'b1; wr_data = hi; end
               FN_MFLO:  begin wr_en = 1'b1; wr_data = lo; end
               FN_MTHI:  begin hilo_we = 1'b1; hi_next = rs_val; end
               FN_MTLO:  begin hilo_we = 1'b1; lo_next = rs_val; end
               FN_MULT:  begin hilo_we = 1'b1; {hi_next, lo_next} = smul; end
               FN_MULTU: begin hilo_we = 1'b1; {hi_next, lo_next} = umul; end
`endif
               default: ;
            endcase
         end
         OP_J:     npc_next = j_target;
         OP_JAL:   begin npc_next = j_target; wr_en = 1'b1; wr_addr = 5'd31; wr_data = link_addr; end
         OP_BEQ:   if (rs_val == rt_val) npc_next = br_target;
         OP_BNE:   if (rs_val != rt_val) npc_next = br_target;
         OP_BLEZ:  if (rs_val[31] || rs_val == '0) npc_next = br_target;
         OP_BGTZ:  if (!rs_val[31] && rs_val != '0) npc_next = br_target;
         OP_ADDIU: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + simm; end
         OP_SLTI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, $signed(rs_val) < $signed(simm)}; end
         OP_SLTIU: begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, rs_val < simm}; end
         OP_ANDI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & zimm; end
         OP_ORI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | zimm; end
         OP_XORI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ zimm; end
         OP_LUI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = {imm, 16'd0}; end
         OP_LW:    begin is_load = 1'b1; wr_en = 1'b1; wr_addr = rt; wr_data = data_readdata; end
         OP_SW:    is_store = 1'b1;
         default: ;
      endcase
   end

   // PC pair implements the delay slot; active drops on the edge that loads PC=0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc     <= RESET_VECTOR;
         npc    <= RESET_VECTOR + 32'd4;
         active <= 1'b1;
         for (int i = 0; i < int'(NREGS); i++) begin
            gpr[i] <= '0;
         end
      end else if (advance) begin
         pc     <= npc;
         npc    <= npc_next;
         active <= (npc != '0);
         if (wr_en && wr_addr != 5'd0) begin
            gpr[wr_addr] <= wr_data;
         end
      end
   end

`ifdef MIPS_MULDIV_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (advance && hilo_we) begin
         hi <= hi_next;
         lo <= lo_next;
      end
   end
`endif

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Self-checking bench for mips_harvard_cpu: directed program table, stall/reset sequences,
// and random programs checked against an instruction-level reference model.
module tb_mips_harvard_cpu;

   localparam logic [31:0] RV  = 32'hBFC00000;
   localparam logic [31:0] NOP = 32'h00000000;
   localparam logic [31:0] JR0 = 32'h00000008;

   logic        clk;
   logic        reset;
   logic        active;
   logic [31:0] register_v0;
   logic        clk_enable;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;

   logic [31:0] rom  [256];
   logic [31:0] dmem [64];
   logic        dmem_clr;
   logic [31:0] rom_off;

   logic [31:0] m_reg [32];
   logic [31:0] m_mem [64];

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0][31:0] prog;
      logic [31:0]      exp_v0;
      int               exp_wr;
   } vec_t;

   vec_t vecs [13];

   mips_harvard_cpu dut (
      .clk           (clk),
      .reset         (reset),
      .active        (active),
      .register_v0   (register_v0),
      .clk_enable    (clk_enable),
      .instr_address (instr_address),
      .instr_readdata(instr_readdata),
      .data_address  (data_address),
      .data_write    (data_write),
      .data_read     (data_read),
      .data_writedata(data_writedata),
      .data_readdata (data_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rom_off = instr_address - RV;
      instr_readdata = (rom_off < 32'd1024) ? rom[rom_off[9:2]] : NOP;
   end

   always_comb begin
      data_readdata = (data_address < 32'd256) ? dmem[data_address[7:2]] : 32'd0;
   end

   always @(posedge clk) begin
      if (dmem_clr) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
      end else if (data_write) begin
         dmem[data_address[7:2]] <= data_writedata;
      end
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
      return {op, addr[27:2]};
   endfunction

   function automatic vec_t mkv(input logic [31:0] v0, input int wr,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] w4, input logic [31:0] w5);
      vec_t v;
      v.prog    = '0;
      v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
      v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
      v.exp_v0  = v0;
      v.exp_wr  = wr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = NOP;
   endtask

   // Reset the core and memory, then clock until halt (optionally with random stalls).
   task automatic run_prog(input bit stall, output int wr_cnt);
      int cyc;
      clk_enable = 1'b1;
      reset      = 1'b1;
      dmem_clr   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset    = 1'b0;
      dmem_clr = 1'b0;
      wr_cnt   = 0;
      cyc      = 0;
      while (active === 1'b1 && cyc < 400) begin
         clk_enable = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (data_write === 1'b1) wr_cnt++;
         @(negedge clk);
         cyc++;
      end
      clk_enable = 1'b1;
      #1;
      chk("halt_within_budget", {31'd0, active}, 32'd0);
   endtask

   // Instruction-level reference: executes the ROM image with a PC/next-PC pair.
   task automatic iss_run();
      logic [31:0] pc, npc, nx, ins, a, b, simm, zimm, res, addr, off;
      logic [4:0]  wa;
      logic        we;
      int          steps;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
      pc = RV; npc = RV + 32'd4; steps = 0;
      while (pc != 32'd0 && steps < 500) begin
         off  = pc - RV;
         ins  = (off < 32'd1024) ? rom[off[9:2]] : NOP;
         a    = m_reg[ins[25:21]];
         b    = m_reg[ins[20:16]];
         simm = {{16{ins[15]}}, ins[15:0]};
         zimm = {16'd0, ins[15:0]};
         addr = a + simm;
         nx   = npc + 32'd4;
         we   = 1'b1; wa = ins[20:16]; res = 32'd0;
         case (ins[31:26])
            6'h00: begin
               wa = ins[15:11];
               case (ins[5:0])
                  6'h00: res = b << ins[10:6];
                  6'h02: res = b >> ins[10:6];
                  6'h03: res = $signed(b) >>> ins[10:6];
                  6'h04: res = b << a[4:0];
                  6'h06: res = b >> a[4:0];
                  6'h07: res = $signed(b) >>> a[4:0];
                  6'h08: begin nx = a; we = 1'b0; end
                  6'h09: begin nx = a; res = pc + 32'd8; end
                  6'h21: res = a + b;
                  6'h23: res = a - b;
                  6'h24: res = a & b;
                  6'h25: res = a | b;
                  6'h26: res = a ^ b;
                  6'h27: res = ~(a | b);
                  6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                  default: we = 1'b0;
               endcase
            end
            6'h02: begin nx = {npc[31:28], ins[25:0], 2'b00}; we = 1'b0; end
            6'h03: begin nx = {npc[31:28], ins[25:0], 2'b00}; wa = 5'd31; res = pc + 32'd8; end
            6'h04: begin we = 1'b0; if (a == b) nx = npc + (simm << 2); end
            6'h05: begin we = 1'b0; if (a != b) nx = npc + (simm << 2); end
            6'h06: begin we = 1'b0; if ($signed(a) <= 0) nx = npc + (simm << 2); end
            6'h07: begin we = 1'b0; if ($signed(a) > 0) nx = npc + (simm << 2); end
            6'h09: res = a + simm;
            6'h0A: res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
            6'h0B: res = (a < simm) ? 32'd1 : 32'd0;
            6'h0C: res = a & zimm;
            6'h0D: res = a | zimm;
            6'h0E: res = a ^ zimm;
            6'h0F: res = {ins[15:0], 16'd0};
            6'h23: res = m_mem[addr[7:2]];
            6'h2B: begin m_mem[addr[7:2]] = b; we = 1'b0; end
            default: we = 1'b0;
         endcase
         if (we && wa != 5'd0) m_reg[wa] = res;
         pc = npc; npc = nx; steps++;
      end
   endtask

   function automatic logic [31:0] rand_instr(input int idx, input int jr_idx);
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      int          k, kmax;
      logic [5:0]  rfn [14];
      logic [5:0]  iop [7];
      logic [5:0]  bop [4];
      rfn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      iop = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      bop = '{6'h04, 6'h05, 6'h06, 6'h07};
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      sh  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      k   = $urandom_range(0, 26);
      if (k < 14) return enc_r(rs, rt, rd, sh, rfn[k]);
      if (k < 21) return enc_i(iop[k-14], rs, rt, imm);
      if (k == 21) return enc_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
      if (k == 22) return enc_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
      kmax = jr_idx - idx - 1;
      if (kmax > 4) kmax = 4;
      return enc_i(bop[k-23], rs, rt, 16'($urandom_range(0, kmax)));
   endfunction

   initial begin
      int wr;
      int cyc;
      int p;
      clk_enable = 1'b1;
      reset      = 1'b1;
      dmem_clr   = 1'b1;
      clear_rom();

      vecs[0]  = mkv(32'd11, 0, enc_i(6'h09, 0, 2, 16'd11), JR0, NOP, NOP, NOP, NOP);
      vecs[1]  = mkv(32'd0, 0, enc_i(6'h09, 0, 4, 16'd11), enc_i(6'h0A, 4, 2, 16'hFFB3),
                     JR0, NOP, NOP, NOP);
      vecs[2]  = mkv(32'd1, 0, enc_i(6'h09, 0, 4, 16'd11), enc_i(6'h0B, 4, 2, 16'hFFB3),
                     JR0, NOP, NOP, NOP);
      vecs[3]  = mkv(32'h1234, 1, enc_i(6'h09, 0, 3, 16'h1234), enc_i(6'h2B, 0, 3, 16'h0010),
                     enc_i(6'h23, 0, 2, 16'h0010), JR0, NOP, NOP);
      vecs[4]  = mkv(32'd1, 0, enc_i(6'h04, 0, 0, 16'd2), enc_i(6'h09, 2, 2, 16'd1),
                     enc_i(6'h09, 2, 2, 16'd5), JR0, NOP, NOP);
      vecs[5]  = mkv(32'hF8000000, 0, enc_i(6'h0F, 0, 2, 16'h8000), enc_r(0, 2, 2, 4, 6'h03),
                     JR0, NOP, NOP, NOP);
      vecs[6]  = mkv(32'hBFC00008, 0, enc_j(6'h03, RV + 32'd12), NOP, enc_i(6'h09, 0, 2, 16'd99),
                     enc_r(31, 0, 2, 0, 6'h21), JR0, NOP);
      vecs[7]  = mkv(32'hBFC00008, 0, enc_r(5, 0, 2, 0, 6'h09), NOP, NOP, NOP, NOP, NOP);
      vecs[8]  = mkv(32'd5, 0, enc_i(6'h09, 0, 2, 16'd5), 32'hFC02FFFF, JR0, NOP, NOP, NOP);
      vecs[9]  = mkv(32'd3, 0, enc_i(6'h09, 0, 2, 16'd3), enc_i(6'h09, 0, 0, 16'd9),
                     enc_r(2, 0, 2, 0, 6'h21), JR0, NOP, NOP);
      vecs[10] = mkv(32'd5, 0, enc_i(6'h09, 0, 4, 16'hFFFF), enc_i(6'h07, 4, 0, 16'd2),
                     enc_i(6'h09, 2, 2, 16'd1), enc_i(6'h09, 2, 2, 16'd4), JR0, NOP);
      vecs[11] = mkv(32'd1, 0, enc_i(6'h09, 0, 4, 16'hFFFF), enc_i(6'h06, 4, 0, 16'd2),
                     enc_i(6'h09, 2, 2, 16'd1), enc_i(6'h09, 2, 2, 16'd4), JR0, NOP);
      vecs[12] = mkv(32'hFFFFF0F0, 0, enc_i(6'h0D, 0, 3, 16'hF0F0), enc_i(6'h0E, 3, 3, 16'hFFFF),
                     enc_r(3, 0, 2, 0, 6'h27), JR0, NOP, NOP);

      // Reset state, and state held while reset stays high across edges.
      repeat (3) @(negedge clk);
      #1;
      chk("reset_pc", instr_address, RV);
      chk("reset_active", {31'd0, active}, 32'd1);
      chk("reset_v0", register_v0, 32'd0);
      chk("reset_no_strobe", {30'd0, data_read, data_write}, 32'd0);
      reset    = 1'b0;
      dmem_clr = 1'b0;

      // Directed program table.
      for (int k = 0; k < 13; k++) begin
         clear_rom();
         for (int i = 0; i < 8; i++) rom[i] = vecs[k].prog[i];
         run_prog(1'b0, wr);
         chk($sformatf("vec%0d_v0", k), register_v0, vecs[k].exp_v0);
         chk($sformatf("vec%0d_pc", k), instr_address, 32'd0);
         if (vecs[k].exp_wr >= 0) chk($sformatf("vec%0d_wr_cycles", k), 32'(wr), 32'(vecs[k].exp_wr));
         repeat (3) @(negedge clk);
         #1;
         chk($sformatf("vec%0d_halt_pc_hold", k), instr_address, 32'd0);
         chk($sformatf("vec%0d_halt_v0_hold", k), register_v0, vecs[k].exp_v0);
         chk($sformatf("vec%0d_halt_strobes", k), {30'd0, data_read, data_write}, 32'd0);
      end

      // Five-cycle stall mid-program: state frozen, final result unchanged.
      clear_rom();
      rom[0] = enc_i(6'h09, 0, 2, 16'd11);
      rom[1] = enc_i(6'h09, 2, 2, 16'd1);
      rom[2] = enc_i(6'h09, 2, 2, 16'd1);
      rom[3] = JR0;
      rom[4] = NOP;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clk_enable = 1'b1;
      repeat (2) @(negedge clk);
      clk_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("stall%0d_pc", i), instr_address, RV + 32'd8);
         chk($sformatf("stall%0d_v0", i), register_v0, 32'd12);
      end
      clk_enable = 1'b1;
      cyc = 0;
      while (active === 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      #1;
      chk("stall_final_v0", register_v0, 32'd13);
      chk("stall_final_active", {31'd0, active}, 32'd0);

      // Asynchronous reset from the halted state, away from any clock edge.
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_pc", instr_address, RV);
      chk("async_reset_active", {31'd0, active}, 32'd1);
      chk("async_reset_v0", register_v0, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("reset_hold_pc", instr_address, RV);
      reset = 1'b0;

      // Random programs with random stalls against the reference model.
      for (int t = 0; t < 30; t++) begin
         clear_rom();
         p = 0;
         for (int r = 1; r < 8; r++) begin
            rom[p] = enc_i(6'h0F, 0, 5'(r), 16'($urandom)); p++;
            rom[p] = enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom)); p++;
         end
         for (int i = p; i < p + 20; i++) rom[i] = rand_instr(i, p + 20);
         rom[p+20] = JR0;
         rom[p+21] = NOP;
         iss_run();
         run_prog(1'b1, wr);
         chk($sformatf("rand%0d_v0", t), register_v0, m_reg[2]);
         for (int i = 0; i < 64; i++) begin
            if (dmem[i] !== m_mem[i] || i == 0)
               chk($sformatf("rand%0d_mem%0d", t, i), dmem[i], m_mem[i]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
